// File: rtl/mux_arbitro_rr.sv
// mux_arbitro_rr: round-robin scheduler for two requester lanes feeding a 2:1 mux.
// Each lane writes into its own FIFO. One non-empty lane is granted per cycle, and
// its head word is forwarded on a registered output together with a one-cycle valid pulse.
//
// Ports:
//   clk, reset_L            clock (rising edge), asynchronous active-low reset
//   valid_inN, data_inN     lane N write request and write data
//   ready_outN              lane N FIFO not full (combinational from registered count)
//   pausa                   downstream stall; no grants while high
//   selector                lane of the word currently on data_out
//   valid_out, data_out     forwarded word and its one-cycle valid pulse
//   contador0, contador1    per-lane grant counters, present only when ARB_CONTADORES_EN
//                           is defined
//
// Optional feature macro: ARB_CONTADORES_EN
module mux_arbitro_rr #(
  parameter int unsigned DATA_W     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in0,
  output logic              ready_out0,
  input  logic              valid_in1,
  input  logic [DATA_W-1:0] data_in1,
  output logic              ready_out1,
  input  logic              pausa,
`ifdef ARB_CONTADORES_EN
  output logic [4:0]        contador0,
  output logic [4:0]        contador1,
`endif
  output logic              selector,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned NUM_LANES = 2;

  logic [DATA_W-1:0]    mem [NUM_LANES][FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr [NUM_LANES];
  logic [PTR_W-1:0]     rd_ptr [NUM_LANES];
  logic [CNT_W-1:0]     count  [NUM_LANES];
  logic                 last_grant;

  logic [NUM_LANES-1:0] wr_req_c;
  logic [NUM_LANES-1:0] ready_c;
  logic [NUM_LANES-1:0] eligible_c;
  logic [NUM_LANES-1:0] push_c;
  logic [NUM_LANES-1:0] pop_c;
  logic [DATA_W-1:0]    wr_data_c [NUM_LANES];
  logic                 grant_c;
  logic                 grant_lane_c;

  // Per-lane status and accepted writes
  always_comb begin
    wr_req_c     = {valid_in1, valid_in0};
    wr_data_c[0] = data_in0;
    wr_data_c[1] = data_in1;
    for (int i = 0; i < NUM_LANES; i++) begin
      ready_c[i]    = (count[i] != CNT_W'(FIFO_DEPTH));
      eligible_c[i] = (count[i] != '0);
      push_c[i]     = wr_req_c[i] & ready_c[i];
    end
  end

  // Round-robin pick: on a tie the lane that did not win last time is chosen
  always_comb begin
    grant_c      = ~pausa & (|eligible_c);
    grant_lane_c = (&eligible_c) ? ~last_grant : eligible_c[1];
    pop_c        = '0;
    if (grant_c) begin
      pop_c[grant_lane_c] = 1'b1;
    end
  end

  assign ready_out0 = ready_c[0];
  assign ready_out1 = ready_c[1];

  // FIFO storage; contents need no reset because empty is tracked by count
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push_c[i]) begin
        mem[i][wr_ptr[i]] <= wr_data_c[i];
      end
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (push_c[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop_c[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        case ({push_c[i], pop_c[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Registered output stage; data_out and selector hold when nothing is granted
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      selector   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      valid_out <= grant_c;
      if (grant_c) begin
        data_out   <= mem[grant_lane_c][rd_ptr[grant_lane_c]];
        selector   <= grant_lane_c;
        last_grant <= grant_lane_c;
      end
    end
  end

`ifdef ARB_CONTADORES_EN
  // Per-lane grant counters, wrapping at 32
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      contador0 <= '0;
      contador1 <= '0;
    end else begin
      if (pop_c[0]) begin
        contador0 <= contador0 + 5'd1;
      end
      if (pop_c[1]) begin
        contador1 <= contador1 + 5'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_arbitro_rr.sv
// tb_mux_arbitro_rr: directed table-driven bench for mux_arbitro_rr.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit after the rising edge.
module tb_mux_arbitro_rr;

  logic       clk;
  logic       reset_L;
  logic       valid_in0, valid_in1, pausa;
  logic [1:0] data_in0, data_in1;
  logic       ready_out0, ready_out1;
  logic       selector, valid_out;
  logic [1:0] data_out;
`ifdef ARB_CONTADORES_EN
  logic [4:0] contador0, contador1;
`endif

  int errors = 0;
  int checks = 0;

  mux_arbitro_rr #(.DATA_W(2), .FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .valid_in0  (valid_in0),
    .data_in0   (data_in0),
    .ready_out0 (ready_out0),
    .valid_in1  (valid_in1),
    .data_in1   (data_in1),
    .ready_out1 (ready_out1),
    .pausa      (pausa),
`ifdef ARB_CONTADORES_EN
    .contador0  (contador0),
    .contador1  (contador1),
`endif
    .selector   (selector),
    .valid_out  (valid_out),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       v0;
    logic [1:0] d0;
    logic       v1;
    logic [1:0] d1;
    logic       pz;
    logic       ev;
    logic       es;
    logic [1:0] ed;
    logic       er0;
    logic       er1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst,
                     input logic v0, input logic [1:0] d0,
                     input logic v1, input logic [1:0] d1, input logic pz,
                     input logic ev, input logic es, input logic [1:0] ed,
                     input logic er0, input logic er1);
    vec_t v;
    v.name = name; v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.pz = pz;
    v.ev = ev; v.es = es; v.ed = ed; v.er0 = er0; v.er1 = er1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_in0 = 1'b0; data_in0 = 2'b00;
    valid_in1 = 1'b0; data_in1 = 2'b00;
    pausa     = 1'b0;
  endtask

  // Called on a falling edge; returns on a falling edge with reset released
  task automatic do_reset();
    idle_inputs();
    reset_L = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;

    // Reset state
    chk("rst valid_out", 8'(valid_out), 8'd0);
    chk("rst data_out", 8'(data_out), 8'd0);
    chk("rst selector", 8'(selector), 8'd0);
    chk("rst ready_out0", 8'(ready_out0), 8'd1);
    chk("rst ready_out1", 8'(ready_out1), 8'd1);

    // Mid-stream asynchronous reset
    valid_in0 = 1'b1; data_in0 = 2'b01;
    valid_in1 = 1'b1; data_in1 = 2'b11;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk("pre-reset selector", 8'(selector), 8'd1);
    chk("pre-reset data_out", 8'(data_out), 8'd3);
    #2 reset_L = 1'b0;
    #1;
    chk("async reset valid_out", 8'(valid_out), 8'd0);
    chk("async reset data_out", 8'(data_out), 8'd0);
    chk("async reset selector", 8'(selector), 8'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    chk("post-reset ready_out0", 8'(ready_out0), 8'd1);
    chk("post-reset ready_out1", 8'(ready_out1), 8'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no stale word valid_out", 8'(valid_out), 8'd0);
      @(negedge clk);
    end

    // Lane 0 stream: name rst v0 d0 v1 d1 pz | ev es ed er0 er1
    add("t2 e0", 1, 1, 2'b01, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1);
    add("t2 e1", 0, 1, 2'b10, 0, 2'b00, 0, 1, 0, 2'b01, 1, 1);
    add("t2 e2", 0, 1, 2'b11, 0, 2'b00, 0, 1, 0, 2'b10, 1, 1);
    add("t2 e3", 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 2'b11, 1, 1);
    add("t2 e4", 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 2'b11, 1, 1);
    // Both lanes prefilled under pausa, then alternating drain
    add("t3 p1", 1, 1, 2'b00, 1, 2'b11, 1, 0, 0, 2'b00, 1, 1);
    add("t3 p2", 0, 1, 2'b00, 1, 2'b11, 1, 0, 0, 2'b00, 1, 1);
    add("t3 p3", 0, 1, 2'b00, 1, 2'b11, 1, 0, 0, 2'b00, 1, 1);
    add("t3 r1", 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 2'b00, 1, 1);
    add("t3 r2", 0, 0, 2'b00, 0, 2'b00, 0, 1, 1, 2'b11, 1, 1);
    add("t3 r3", 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 2'b00, 1, 1);
    add("t3 r4", 0, 0, 2'b00, 0, 2'b00, 0, 1, 1, 2'b11, 1, 1);
    add("t3 r5", 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 2'b00, 1, 1);
    add("t3 r6", 0, 0, 2'b00, 0, 2'b00, 0, 1, 1, 2'b11, 1, 1);
    add("t3 r7", 0, 0, 2'b00, 0, 2'b00, 0, 0, 1, 2'b11, 1, 1);
    // Lane 1 overflow under pausa, fifth word refused
    add("t4 f1", 0, 0, 2'b00, 1, 2'b00, 1, 0, 1, 2'b11, 1, 1);
    add("t4 f2", 0, 0, 2'b00, 1, 2'b01, 1, 0, 1, 2'b11, 1, 1);
    add("t4 f3", 0, 0, 2'b00, 1, 2'b10, 1, 0, 1, 2'b11, 1, 1);
    add("t4 f4", 0, 0, 2'b00, 1, 2'b11, 1, 0, 1, 2'b11, 1, 0);
    add("t4 f5", 0, 0, 2'b00, 1, 2'b01, 1, 0, 1, 2'b11, 1, 0);
    add("t4 d1", 0, 0, 2'b00, 0, 2'b00, 0, 1, 1, 2'b00, 1, 1);
    add("t4 d2", 0, 0, 2'b00, 0, 2'b00, 0, 1, 1, 2'b01, 1, 1);
    add("t4 d3", 0, 0, 2'b00, 0, 2'b00, 0, 1, 1, 2'b10, 1, 1);
    add("t4 d4", 0, 0, 2'b00, 0, 2'b00, 0, 1, 1, 2'b11, 1, 1);
    add("t4 d5", 0, 0, 2'b00, 0, 2'b00, 0, 0, 1, 2'b11, 1, 1);
    // Lane 0 stream with a two-cycle pausa after the second output
    add("t5 s1", 0, 1, 2'b01, 0, 2'b00, 0, 0, 1, 2'b11, 1, 1);
    add("t5 s2", 0, 1, 2'b10, 0, 2'b00, 0, 1, 0, 2'b01, 1, 1);
    add("t5 s3", 0, 1, 2'b11, 0, 2'b00, 0, 1, 0, 2'b10, 1, 1);
    add("t5 s4", 0, 1, 2'b00, 0, 2'b00, 1, 0, 0, 2'b10, 1, 1);
    add("t5 s5", 0, 0, 2'b00, 0, 2'b00, 1, 0, 0, 2'b10, 1, 1);
    add("t5 s6", 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 2'b11, 1, 1);
    add("t5 s7", 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 2'b00, 1, 1);
    add("t5 s8", 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1);
    // Full lane 0: write refused in the same cycle as a pop
    add("t7 w1", 0, 1, 2'b01, 0, 2'b00, 1, 0, 0, 2'b00, 1, 1);
    add("t7 w2", 0, 1, 2'b10, 0, 2'b00, 1, 0, 0, 2'b00, 1, 1);
    add("t7 w3", 0, 1, 2'b11, 0, 2'b00, 1, 0, 0, 2'b00, 1, 1);
    add("t7 w4", 0, 1, 2'b00, 0, 2'b00, 1, 0, 0, 2'b00, 0, 1);
    add("t7 w5", 0, 1, 2'b11, 0, 2'b00, 0, 1, 0, 2'b01, 1, 1);
    add("t7 w6", 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 2'b10, 1, 1);
    add("t7 w7", 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 2'b11, 1, 1);
    add("t7 w8", 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 2'b00, 1, 1);
    add("t7 w9", 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      valid_in0 = vecs[k].v0; data_in0 = vecs[k].d0;
      valid_in1 = vecs[k].v1; data_in1 = vecs[k].d1;
      pausa     = vecs[k].pz;
      @(posedge clk); #1;
      chk({vecs[k].name, " valid_out"},  8'(valid_out),  8'(vecs[k].ev));
      chk({vecs[k].name, " selector"},   8'(selector),   8'(vecs[k].es));
      chk({vecs[k].name, " data_out"},   8'(data_out),   8'(vecs[k].ed));
      chk({vecs[k].name, " ready_out0"}, 8'(ready_out0), 8'(vecs[k].er0));
      chk({vecs[k].name, " ready_out1"}, 8'(ready_out1), 8'(vecs[k].er1));
      @(negedge clk);
    end

`ifdef ARB_CONTADORES_EN
    // Grant counters: 33 words on lane 0 and 2 on lane 1
    do_reset();
    for (int i = 0; i < 33; i++) begin
      valid_in0 = 1'b1; data_in0 = 2'(i);
      valid_in1 = (i < 2); data_in1 = 2'b10;
      @(negedge clk);
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("contador0 wrap", 8'(contador0), 8'd1);
    chk("contador1", 8'(contador1), 8'd2);
    reset_L = 1'b0;
    #1;
    chk("contador0 reset", 8'(contador0), 8'd0);
    chk("contador1 reset", 8'(contador1), 8'd0);
    @(negedge clk);
    reset_L = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
